// File: rtl/qos_pkg.sv
// rtl/qos_pkg.sv - shared types and result codes for the QoS TS switch path
package qos_pkg;

    localparam int NUM_CH = 4;

    typedef logic [1:0] ch_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        HOLDOFF   = 2'd2
    } seq_state_t;

    localparam logic [1:0] RES_NONE     = 2'b00;
    localparam logic [1:0] RES_SWITCHED = 2'b01;
    localparam logic [1:0] RES_TIMEOUT  = 2'b10;
    localparam logic [1:0] RES_REJECTED = 2'b11;

endpackage

// File: rtl/qos_cycle_timer.sv
// rtl/qos_cycle_timer.sv - loadable down-counter, tc flags a count of zero
module qos_cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load wins over decrement; the count parks at zero instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/ts_switch_sequencer.sv
// rtl/ts_switch_sequencer.sv - hitless TS mux switchover sequencer
// Optional switch counter enabled by defining TS_SWITCH_COUNT_EN.
module ts_switch_sequencer
    import qos_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int DEFAULT_CH     = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_channel,
    input  logic [NUM_CH-1:0] valid,
    input  logic [NUM_CH-1:0] sync,
    input  logic [19:0]       holdoff_cycles,
    output logic [1:0]        mux_control,
    output logic              en_reset_counter,
    output logic              abort,
    output logic [1:0]        last_result,
    output logic              busy,
    output logic [15:0]       switch_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam ch_t DEF_CH = ch_t'(DEFAULT_CH);
    localparam logic [TW-1:0] TO_LOAD = TW'(TIMEOUT_CYCLES - 1);

    seq_state_t  state_q, state_d;
    ch_t         target_q, target_d;
    ch_t         mux_q, mux_d;
    logic        en_reset_counter_q, en_reset_counter_d;
    logic        abort_q, abort_d;
    logic [1:0]  result_q, result_d;

    logic        to_load, to_dec, to_tc;
    logic        ho_load, ho_dec, ho_tc;
    logic [19:0] ho_value;

    // Timeout timer is preloaded with TIMEOUT_CYCLES-1 and expires at zero.
    qos_cycle_timer #(.W(TW)) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .load       (to_load),
        .load_value (TO_LOAD),
        .dec        (to_dec),
        .tc         (to_tc)
    );

    qos_cycle_timer #(.W(20)) u_holdoff (
        .clk        (clk),
        .rst        (rst),
        .load       (ho_load),
        .load_value (ho_value),
        .dec        (ho_dec),
        .tc         (ho_tc)
    );

    // A latched value of 0 or 1 both give a single HOLDOFF cycle.
    assign ho_value = (holdoff_cycles == 20'd0) ? 20'd0 : holdoff_cycles - 20'd1;

    always_comb begin
        state_d            = state_q;
        target_d           = target_q;
        mux_d              = mux_q;
        en_reset_counter_d = 1'b0;
        abort_d            = 1'b0;
        result_d           = result_q;
        to_load            = 1'b0;
        to_dec             = 1'b0;
        ho_load            = 1'b0;
        ho_dec             = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid && (req_channel != mux_q)) begin
                    if (!valid[req_channel]) begin
                        abort_d  = 1'b1;
                        result_d = RES_REJECTED;
                    end else begin
                        target_d = req_channel;
                        to_load  = 1'b1;
                        state_d  = WAIT_SYNC;
                    end
                end
            end
            WAIT_SYNC: begin
                if (sync[target_q] && valid[target_q]) begin
                    mux_d              = target_q;
                    en_reset_counter_d = 1'b1;
                    result_d           = RES_SWITCHED;
                    ho_load            = 1'b1;
                    state_d            = HOLDOFF;
                end else if (!valid[target_q]) begin
                    abort_d  = 1'b1;
                    result_d = RES_REJECTED;
                    state_d  = IDLE;
                end else if (to_tc) begin
                    abort_d  = 1'b1;
                    result_d = RES_TIMEOUT;
                    state_d  = IDLE;
                end else begin
                    to_dec = 1'b1;
                end
            end
            HOLDOFF: begin
                if (ho_tc) begin
                    state_d = IDLE;
                end else begin
                    ho_dec = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= IDLE;
            target_q           <= DEF_CH;
            mux_q              <= DEF_CH;
            en_reset_counter_q <= 1'b0;
            abort_q            <= 1'b0;
            result_q           <= RES_NONE;
        end else begin
            state_q            <= state_d;
            target_q           <= target_d;
            mux_q              <= mux_d;
            en_reset_counter_q <= en_reset_counter_d;
            abort_q            <= abort_d;
            result_q           <= result_d;
        end
    end

`ifdef TS_SWITCH_COUNT_EN
    logic [15:0] switch_count_q, switch_count_d;

    always_comb begin
        switch_count_d = switch_count_q;
        if (en_reset_counter_d && (switch_count_q != 16'hFFFF)) begin
            switch_count_d = switch_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            switch_count_q <= 16'd0;
        end else begin
            switch_count_q <= switch_count_d;
        end
    end

    assign switch_count = switch_count_q;
`else
    assign switch_count = 16'd0;
`endif

    assign req_ready        = (state_q == IDLE);
    assign busy             = (state_q != IDLE);
    assign mux_control      = mux_q;
    assign en_reset_counter = en_reset_counter_q;
    assign abort            = abort_q;
    assign last_result      = result_q;

endmodule

// File: doc/ts_switch_sequencer.md
Name: ts_switch_sequencer

Overview:
- Sequences hitless TS input-mux switchover for the 4-channel QoS path.
- Accepts a switch request (target channel) from main control logic and waits for the target channel's packet-start sync pulse before moving the mux select.
- On each switch, pulses the error-counter reset, then enforces a programmable hold-off before the next request.
- Sits between the main control/MM config logic and the TS mux plus per-channel error counters.

Parameters:
TIMEOUT_CYCLES, 4096, max cycles spent in WAIT_SYNC before aborting (>=1)
DEFAULT_CH, 0, mux_control value after reset (0..3)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req_valid  in  1  switch request valid
req_ready  out  1  request accepted when req_valid && req_ready; combinational, = (state==IDLE)
req_channel  in  2  target channel 0..3
valid  in  4  per-channel signal presence, bit n = channel n
sync  in  4  per-channel packet-start pulse, bit n = channel n
holdoff_cycles  in  20  post-switch hold-off length, sampled at switch
mux_control  out  2  registered mux select
en_reset_counter  out  1  one-cycle pulse coincident with the first cycle of new mux_control
abort  out  1  one-cycle pulse when a request fails
last_result  out  2  00 none, 01 switched, 10 timeout, 11 rejected/lost
busy  out  1  state != IDLE
switch_count  out  16  see Optional Feature

Behaviour:
- Reset (rst=1 sampled at any edge, including mid-operation):
  - state=IDLE, mux_control=DEFAULT_CH, en_reset_counter=0, abort=0, last_result=00, internal counters=0.
- States: IDLE, WAIT_SYNC, HOLDOFF.
- IDLE, on accept:
  - req_channel==mux_control: no-op; stay IDLE; no pulses; last_result unchanged.
  - valid[req_channel]==0: stay IDLE; abort=1 next cycle; last_result=11.
  - else: latch target, clear timer, go to WAIT_SYNC. sync in the accept cycle is ignored.
- WAIT_SYNC (timer increments each cycle):
  - sync[target] && valid[target]: mux_control<=target; en_reset_counter=1 for 1 cycle; last_result=01; latch holdoff_cycles; go to HOLDOFF.
  - else valid[target]==0: abort pulse; last_result=11; go to IDLE.
  - else timer==TIMEOUT_CYCLES-1: abort pulse; last_result=10; go to IDLE.
  - Priority: sync > lost > timeout. Sync on the final timeout cycle succeeds.
  - sync on other channels is ignored.
- HOLDOFF:
  - Count latched value down to 0, then go to IDLE.
  - Latched value 0 means 1 cycle in HOLDOFF (IDLE on the next edge).
  - Duration = max(1, holdoff_cycles) cycles.
  - Later changes to holdoff_cycles do not affect the current hold-off.
- Latency: accept at edge N; earliest mux change at edge N+1 if sync[target] is high in cycle N+1.
- Timer width: $clog2(TIMEOUT_CYCLES+1). Hold-off counter is 20 bits, no wrap.
- abort and en_reset_counter are never high in the same cycle.

Optional Feature:
- Macro: TS_SWITCH_COUNT_EN.
- Defined: switch_count increments on each en_reset_counter pulse, saturates at 16'hFFFF, and resets to 0.
- Undefined: switch_count is driven constant 0 and the counter logic is absent.
- The port exists in both builds.

Decomposition:
- Shared package qos_pkg:
  - NUM_CH=4, ch_t (2-bit).
  - seq_state_t enum {IDLE, WAIT_SYNC, HOLDOFF}.
  - Result constants RES_NONE/RES_SWITCHED/RES_TIMEOUT/RES_REJECTED.
- One natural sub-module: qos_cycle_timer (loadable counter with terminal-count flag), instanced for both timeout and hold-off.

Test Plan:
- Reset, then req_channel=2 with valid=4'b1111, sync[2] pulsed 5 cycles after accept -> mux_control 0->2 at that edge; en_reset_counter 1 cycle; last_result=01; busy until hold-off ends.
- TIMEOUT_CYCLES=16, req_channel=1, sync[1] never pulsed -> abort exactly 16 cycles after WAIT_SYNC entry; last_result=10; mux_control unchanged.
- req_channel=3 with valid[3]=0 -> no WAIT_SYNC; abort next cycle; last_result=11. Repeat with valid[3] dropping mid-wait -> abort, 11.
- holdoff_cycles=30 after a switch -> req_ready low for 30 cycles; a request held on req_valid is accepted on cycle 31. Repeat with holdoff_cycles=0 -> 1-cycle HOLDOFF.
- rst asserted during WAIT_SYNC and during HOLDOFF -> next cycle IDLE, mux_control=DEFAULT_CH, no pulses. Request for the current channel -> no-op, no pulses.
- TS_SWITCH_COUNT_EN defined: 3 successful switches -> switch_count=3; counter preloaded to 16'hFFFF -> stays 16'hFFFF. Undefined: stays 0.
